// File: rtl/adder4_seq_ctrl.sv
// Wide-add sequencer: feeds one shared external 4-bit adder a nibble per cycle (LSB first)
// and returns the W-bit sum, carry and signed overflow through valid/ready handshakes.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands; adder pins held at 0
// RUN   | one nibble per edge through the shared adder, idx selects the slice
// DONE  | result presented on out_valid, held until out_ready
module adder4_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            carry_reg;
    logic            cout_reg;
    logic            ovf_reg;
    logic [IW-1:0]   idx;
    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic            accept;
    logic            deliver;
    logic            last_step;

    assign accept    = (state == IDLE) && in_valid;
    assign deliver   = (state == DONE) && out_ready;
    assign last_step = (state == RUN) && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (deliver) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                nib_a = a_reg[4*i +: 4];
                nib_b = b_reg[4*i +: 4];
            end
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state == RUN) begin
            add_a   = nib_a;
            add_b   = nib_b;
            add_cin = carry_reg;
        end
    end

    // Results survive the return to IDLE; they change only when the next RUN overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IW'(i)) begin
                    sum_reg[4*i +: 4] <= add_sum;
                end
            end
            carry_reg <= add_cout;
            if (last_step) begin
                cout_reg <= add_cout;
                ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// Scoreboard bench for adder4_seq_ctrl (NIBBLES=4) with a behavioural 4-bit adder on the shared pins.
module tb_adder4_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [3:0]  add_sum;
    logic        add_cout;
    logic [4:0]  add_res;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          pushed = 0;
    int          received = 0;
    time         acc_t;
    logic [17:0] sb[$];

    always #5 clk = ~clk;

    assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
    assign add_sum  = add_res[3:0];
    assign add_cout = add_res[4];

    adder4_seq_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else pass_cnt++;
    endtask

    // Expected word is {sum, cout, ovf}; pushed on the accepting edge when do_push is set.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         input logic [17:0] exp, input bit do_push);
        int waited = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        cin = tc;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        if (do_push) begin
            sb.push_back(exp);
            pushed++;
        end
        @(posedge clk);
        acc_t = $time;
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                received++;
                if (sb.size() == 0) begin
                    chk("unexpected_result", {15'd0, sum, cout}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("result_sum", {16'd0, sum}, {16'd0, e[17:2]});
                    chk("result_cout", {31'd0, cout}, {31'd0, e[1]});
                    chk("result_ovf", {31'd0, ovf}, {31'd0, e[0]});
                end
            end
        end
    end

    initial begin : driver
        time prev_t;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outs", {12'd0, sum, cout, ovf, out_valid, busy}, 32'd0);
        chk("rst_adder_pins", {23'd0, add_a, add_b, add_cin}, 32'd0);
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain add: nibble sequence on add_a and 4-edge latency
        issue(16'h1234, 16'h4321, 1'b0, {16'h5555, 1'b0, 1'b0}, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_add_a_seq", {28'd0, add_a}, 32'(4 - i));
            chk("t1_not_valid_yet", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        chk("t1_latency_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Signed overflow cases
        issue(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1}, 1'b1);
        drain();
        issue(16'h8000, 16'h8000, 1'b0, {16'h0000, 1'b1, 1'b1}, 1'b1);
        drain();

        // Backpressure with pending operands, then the full-ripple carry case
        out_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b0, {16'h5555, 1'b0, 1'b0}, 1'b1);
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'h0000;
        cin = 1'b1;
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", {14'd0, sum, cout, ovf}, {14'd0, 16'h5555, 2'b00});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_idle", {31'd0, busy}, 32'd0);
        sb.push_back({16'h0000, 1'b1, 1'b0});
        pushed++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_add_cin_ripple", {31'd0, add_cin}, 32'd1);
            chk("t2_busy", {31'd0, busy}, 32'd1);
        end
        drain();

        // Back-to-back transactions with out_ready held high
        prev_t = 0;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: issue(16'h0001, 16'h0001, 1'b1, {16'h0003, 1'b0, 1'b0}, 1'b1);
                1: issue(16'hABCD, 16'h1111, 1'b0, {16'hBCDE, 1'b0, 1'b0}, 1'b1);
                default: issue(16'h9999, 16'h9999, 1'b0, {16'h3332, 1'b1, 1'b1}, 1'b1);
            endcase
            if (i > 0) chk("b2b_spacing", 32'(acc_t - prev_t), 32'd60);
            prev_t = acc_t;
        end
        drain();

        // Asynchronous reset two edges into RUN aborts with no result
        issue(16'h1111, 16'h2222, 1'b0, 18'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("amid_outs", {12'd0, sum, cout, ovf, out_valid, busy}, 32'd0);
        chk("amid_adder_pins", {23'd0, add_a, add_b, add_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(16'h0F0F, 16'h00F1, 1'b0, {16'h1000, 1'b0, 1'b0}, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        chk("result_count", received, pushed);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
